pong_game_core: RTL and testbench



---
 rtl/pong_game_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_pong_game_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_core.sv
// pong_game_core: two-player pong engine with per-frame ball and paddle motion, scoring FSM and registered pixel enables.
// Build option: define PONG_SPEEDUP_EN so each paddle hit raises |vx| by one, capped at BALL_SPEED_MAX.
module pong_game_core #(
    parameter int COORD_W        = 11,
    parameter int ACTIVE_COLS    = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int BALL_SIZE      = 8,
    parameter int PADDLE_W       = 8,
    parameter int PADDLE_H       = 64,
    parameter int PADDLE_MARGIN  = 16,
    parameter int PADDLE_STEP    = 4,
    parameter int BALL_SPEED     = 2,
    parameter int BALL_SPEED_MAX = 6,
    parameter int SCORE_W        = 4,
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_FRAMES   = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               p1_up,
    input  logic               p1_dn,
    input  logic               p2_up,
    input  logic               p2_dn,
    input  logic               start,
    output logic               ball_on,
    output logic               paddle_on,
    output logic               pixel_on,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state,
    output logic               game_over
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam int SC_W = $clog2(SERVE_FRAMES + 1);

    typedef logic signed [COORD_W:0] sc_t;
    localparam sc_t ZERO   = sc_t'(0);
    localparam sc_t BS     = sc_t'(BALL_SIZE);
    localparam sc_t PW     = sc_t'(PADDLE_W);
    localparam sc_t PH     = sc_t'(PADDLE_H);
    localparam sc_t PSTEP  = sc_t'(PADDLE_STEP);
    localparam sc_t SPD    = sc_t'(BALL_SPEED);
    localparam sc_t VX_MAX = sc_t'(BALL_SPEED_MAX);
    localparam sc_t COLS   = sc_t'(ACTIVE_COLS);
    localparam sc_t ROWS   = sc_t'(ACTIVE_ROWS);
    localparam sc_t BX0    = sc_t'((ACTIVE_COLS - BALL_SIZE) / 2);
    localparam sc_t BY0    = sc_t'((ACTIVE_ROWS - BALL_SIZE) / 2);
    localparam sc_t PY0    = sc_t'((ACTIVE_ROWS - PADDLE_H) / 2);
    localparam sc_t BX_MAX = sc_t'(ACTIVE_COLS - BALL_SIZE);
    localparam sc_t BY_MAX = sc_t'(ACTIVE_ROWS - BALL_SIZE);
    localparam sc_t PY_MAX = sc_t'(ACTIVE_ROWS - PADDLE_H);
    localparam sc_t P1_X   = sc_t'(PADDLE_MARGIN);
    localparam sc_t P2_X   = sc_t'(ACTIVE_COLS - PADDLE_MARGIN - PADDLE_W);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [SC_W-1:0]    SERVE_LOAD = SC_W'(SERVE_FRAMES);
    localparam logic [SC_W-1:0]    SC_ONE     = SC_W'(1);
`ifdef PONG_SPEEDUP_EN
    localparam sc_t SPEED_INC = sc_t'(1);
`else
    localparam sc_t SPEED_INC = sc_t'(0);
`endif

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    sc_t                vx_q, vx_d, vy_q, vy_d;
    logic [COORD_W-1:0] pad_y_q [2];
    logic [COORD_W-1:0] pad_y_d [2];
    logic [SC_W-1:0]    serve_cnt_q, serve_cnt_d;
    logic               serve_pos_q, serve_pos_d;   // next serve heads toward +x
    logic               p1_scored_q, p1_scored_d;
    logic               ball_on_q, ball_on_d, paddle_on_q, paddle_on_d, pixel_on_q, pixel_on_d;

    sc_t bx_s, by_s, nx, ny, ny_res, vy_res, rc, rr, vx_mag, vx_hit;
    logic [1:0] pad_up, pad_dn, pad_ov, pad_cov;
    logic [COORD_W-1:0] pad_next [2];
    logic hit_p1, hit_p2, in_view;

    assign bx_s   = $signed({1'b0, bx_q});
    assign by_s   = $signed({1'b0, by_q});
    assign nx     = bx_s + vx_q;
    assign ny     = by_s + vy_q;
    assign rc     = $signed({1'b0, col});
    assign rr     = $signed({1'b0, row});
    assign pad_up = {p2_up, p1_up};
    assign pad_dn = {p2_dn, p1_dn};

    always_comb begin
        ny_res = ny;
        vy_res = vy_q;
        if (ny <= ZERO) begin
            ny_res = ZERO;
            vy_res = -vy_q;
        end else if (ny >= BY_MAX) begin
            ny_res = BY_MAX;
            vy_res = -vy_q;
        end
    end

    // Per-paddle next position, overlap with the ball's resolved row and raster coverage.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pad
        localparam sc_t PX = (gi == 0) ? P1_X : P2_X;
        sc_t py, up_y, dn_y;
        assign py   = $signed({1'b0, pad_y_q[gi]});
        assign up_y = (py >= PSTEP) ? py - PSTEP : ZERO;
        assign dn_y = (py + PSTEP >= PY_MAX) ? PY_MAX : py + PSTEP;
        assign pad_next[gi] = (pad_up[gi] == pad_dn[gi]) ? pad_y_q[gi]
                            : pad_up[gi] ? up_y[COORD_W-1:0] : dn_y[COORD_W-1:0];
        assign pad_ov[gi]  = (ny_res < py + PH) && (ny_res + BS > py);
        assign pad_cov[gi] = (rc >= PX) && (rc < PX + PW) && (rr >= py) && (rr < py + PH);
    end

    always_comb begin
        in_view     = (rr < ROWS) && (rc < COLS);
        ball_on_d   = in_view && (state_q != S_IDLE) && (rc >= bx_s) && (rc < bx_s + BS)
                      && (rr >= by_s) && (rr < by_s + BS);
        paddle_on_d = in_view && (pad_cov != 2'b00);
        pixel_on_d  = ball_on_d || paddle_on_d;
    end

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        bx_d        = bx_q;
        by_d        = by_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        pad_y_d     = pad_y_q;
        serve_cnt_d = serve_cnt_q;
        serve_pos_d = serve_pos_q;
        p1_scored_d = p1_scored_q;
        vx_mag      = (vx_q < ZERO) ? -vx_q : vx_q;
        vx_hit      = ((SPEED_INC != ZERO) && (vx_mag >= VX_MAX)) ? VX_MAX : vx_mag + SPEED_INC;
        hit_p1      = (vx_q < ZERO) && (nx <= P1_X + PW) && (nx + BS > P1_X) && pad_ov[0];
        hit_p2      = (vx_q > ZERO) && (nx + BS >= P2_X) && (nx < P2_X + PW) && pad_ov[1];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    pad_y_d = pad_next;
                    bx_d    = BX0[COORD_W-1:0];
                    by_d    = BY0[COORD_W-1:0];
                    if (serve_cnt_q <= SC_ONE) begin
                        state_d     = S_PLAY;
                        serve_cnt_d = '0;
                        vx_d        = serve_pos_q ? SPD : -SPD;
                        vy_d        = SPD;
                    end else begin
                        serve_cnt_d = serve_cnt_q - 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    pad_y_d = pad_next;
                    // Paddle returns take precedence over the edge-miss test.
                    if (hit_p1 || hit_p2) begin
                        bx_d = hit_p1 ? P1_X[COORD_W-1:0] + PW[COORD_W-1:0]
                                      : P2_X[COORD_W-1:0] - BS[COORD_W-1:0];
                        vx_d = hit_p1 ? vx_hit : -vx_hit;
                        by_d = ny_res[COORD_W-1:0];
                        vy_d = vy_res;
                    end else if (nx <= ZERO || nx >= BX_MAX) begin
                        state_d     = S_POINT;
                        p1_scored_d = (nx >= BX_MAX);
                    end else begin
                        bx_d = nx[COORD_W-1:0];
                        by_d = ny_res[COORD_W-1:0];
                        vy_d = vy_res;
                    end
                end
            end
            S_POINT: begin
                if (p1_scored_q && score1_q != WIN_S) score1_d = score1_q + 1'b1;
                if (!p1_scored_q && score2_q != WIN_S) score2_d = score2_q + 1'b1;
                if (score1_d == WIN_S || score2_d == WIN_S) begin
                    state_d = S_OVER;
                end else begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                    serve_pos_d = p1_scored_q;
                    bx_d        = BX0[COORD_W-1:0];
                    by_d        = BY0[COORD_W-1:0];
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d     = S_SERVE;
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_cnt_d = SERVE_LOAD;
                    serve_pos_d = 1'b1;
                    bx_d        = BX0[COORD_W-1:0];
                    by_d        = BY0[COORD_W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            bx_q        <= BX0[COORD_W-1:0];
            by_q        <= BY0[COORD_W-1:0];
            vx_q        <= SPD;
            vy_q        <= SPD;
            pad_y_q[0]  <= PY0[COORD_W-1:0];
            pad_y_q[1]  <= PY0[COORD_W-1:0];
            serve_cnt_q <= '0;
            serve_pos_q <= 1'b1;
            p1_scored_q <= 1'b0;
            ball_on_q   <= 1'b0;
            paddle_on_q <= 1'b0;
            pixel_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            pad_y_q     <= pad_y_d;
            serve_cnt_q <= serve_cnt_d;
            serve_pos_q <= serve_pos_d;
            p1_scored_q <= p1_scored_d;
            ball_on_q   <= ball_on_d;
            paddle_on_q <= paddle_on_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    assign ball_on   = ball_on_q;
    assign paddle_on = paddle_on_q;
    assign pixel_on  = pixel_on_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign state     = state_q;
    assign game_over = (state_q == S_OVER);
endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: positions are inferred through the registered pixel enables.
module tb_pong_game_core;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n, frame_tick, start;
    logic          p1_up, p1_dn, p2_up, p2_dn;
    logic [CW-1:0] row, col;
    logic          ball_on, paddle_on, pixel_on, game_over;
    logic [3:0]    score1, score2;
    logic [2:0]    state;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    pong_game_core dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .row(row), .col(col),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .start(start),
        .ball_on(ball_on), .paddle_on(paddle_on), .pixel_on(pixel_on),
        .score1(score1), .score2(score2), .state(state), .game_over(game_over)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic probe(input int x, input int y);
        col = CW'(x);
        row = CW'(y);
        cycle();
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        probe(x, y);     check_eq({tag, ".corner"}, int'(ball_on), 1);
        probe(x - 1, y); check_eq({tag, ".left"}, int'(ball_on), 0);
        probe(x, y - 1); check_eq({tag, ".above"}, int'(ball_on), 0);
    endtask

    task automatic check_pad(input string tag, input int x, input int y);
        probe(x, y);      check_eq({tag, ".top"}, int'(paddle_on), 1);
        probe(x, y + 63); check_eq({tag, ".bot"}, int'(paddle_on), 1);
        if (y > 0) begin
            probe(x, y - 1); check_eq({tag, ".above"}, int'(paddle_on), 0);
        end
        if (y + 64 < 480) begin
            probe(x, y + 64); check_eq({tag, ".below"}, int'(paddle_on), 0);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        row = '0; col = '0;
        repeat (3) cycle();
        check_eq("rst.state", int'(state), 0);
        check_eq("rst.score1", int'(score1), 0);
        check_eq("rst.score2", int'(score2), 0);
        check_eq("rst.game_over", int'(game_over), 0);
        check_eq("rst.pixel_on", int'(pixel_on), 0);
        rst_n = 1'b1;
        probe(316, 236); check_eq("idle.ball_hidden", int'(ball_on), 0);
        check_pad("rst.p1", 16, 208);
        check_pad("rst.p2", 616, 208);

        start = 1'b1; cycle(); start = 1'b0;
        check_eq("start.state", int'(state), 1);
        check_ball("serve.centre", 316, 236);
        ticks(59); check_eq("serve.t59", int'(state), 1);
        ticks(1);  check_eq("serve.t60", int'(state), 2);

        p1_up = 1'b1; p2_dn = 1'b1;
        ticks(1);  check_ball("play.k1", 318, 238);
        ticks(50); check_pad("p1.k51", 16, 4);
        ticks(1);  check_pad("p1.k52", 16, 0);
        ticks(8);  check_pad("p1.k60", 16, 0);
        p1_up = 1'b0; p1_dn = 1'b1;
        ticks(5);  check_pad("p1.dn5", 16, 20);
        p1_up = 1'b1;
        ticks(10); check_pad("p1.both", 16, 20);
        p1_up = 1'b0; p1_dn = 1'b0;

        ticks(42); check_ball("k117", 550, 470);
        check_pad("p2.bottom", 616, 416);
        probe(616, 479); check_eq("view.row479", int'(pixel_on), 1);
        probe(616, 480); check_eq("view.row480", int'(pixel_on), 0);
        ticks(1);  check_ball("wall.k118", 552, 472);
        ticks(1);  check_ball("wall.k119", 554, 470);
        ticks(27); check_ball("p2hit.k146", 608, 416);
        ticks(1);  check_ball("p2hit.k147", 606, 414);

        p2_dn = 1'b0; p1_dn = 1'b1;
        ticks(30); p1_dn = 1'b0;
        check_pad("p1.k177", 16, 140);
        ticks(261); check_ball("p1hit.k438", 24, 168);
        ticks(1);   check_ball("p1hit.k439", 26, 170);

        p2_up = 1'b1;
        ticks(302); check_ball("k741", 630, 170);
        check_pad("p2.top", 616, 0);
        check_eq("k741.state", int'(state), 2);
        ticks(1); check_eq("miss.point", int'(state), 3);
        cycle();
        check_eq("miss.serve", int'(state), 1);
        check_eq("miss.score1", int'(score1), 1);
        check_eq("miss.score2", int'(score2), 0);
        check_ball("reserve", 316, 236);
        p2_up = 1'b0;
        ticks(59); check_eq("reserve.t59", int'(state), 1);
        ticks(1);  check_eq("reserve.t60", int'(state), 2);
        ticks(1);  check_ball("relaunch", 318, 238);

        ticks(157); check_eq("r2.point", int'(state), 3);
        cycle();    check_eq("r2.score1", int'(score1), 2);
        for (int r = 3; r <= 9; r++) begin
            ticks(60);
            ticks(158);
            check_eq($sformatf("r%0d.point", r), int'(state), 3);
            cycle();
            check_eq($sformatf("r%0d.score1", r), int'(score1), r);
            check_eq($sformatf("r%0d.state", r), int'(state), (r == 9) ? 4 : 1);
        end
        check_eq("over.game_over", int'(game_over), 1);
        check_eq("over.score2", int'(score2), 0);
        ticks(5); check_eq("over.hold", int'(state), 4);

        start = 1'b1; cycle(); start = 1'b0;
        check_eq("restart.state", int'(state), 1);
        check_eq("restart.score1", int'(score1), 0);
        check_eq("restart.game_over", int'(game_over), 0);
        ticks(60); check_eq("restart.play", int'(state), 2);
        ticks(3);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check_eq("midrst.state", int'(state), 0);
        check_eq("midrst.score1", int'(score1), 0);
        probe(316, 236); check_eq("midrst.ball_hidden", int'(ball_on), 0);

        start = 1'b1; frame_tick = 1'b1; cycle(); start = 1'b0; frame_tick = 1'b0;
        check_eq("coinc.state", int'(state), 1);
        ticks(59); check_eq("coinc.t59", int'(state), 1);
        ticks(1);  check_eq("coinc.t60", int'(state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
